// File: rtl/sprite_move_requester.sv
// Snoops CPU writes to the sprite position/code registers and hands one move at a
// time to the collision checker, then commits or reverts it based on the checker's verdict.
module sprite_move_requester #(
  parameter logic [15:0] POS_BASE  = 16'h5060,
  parameter logic [15:0] CODE_BASE = 16'h4FF0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cpu_wr_en,
  input  logic [15:0]     cpu_addr,
  input  logic [7:0]      cpu_wr_data,
  input  logic            checker_busy,
  input  logic [7:0]      restore,
  output logic            sprite_update,
  output logic [2:0]      update_index,
  output logic [5:0]      sprite_num,
  output logic [7:0][7:0] sprite_x,
  output logic [7:0][7:0] sprite_y,
  output logic [7:0]      pending
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    RESOLVE
  } state_e;

  state_e state_q, state_d;

  logic [7:0][7:0] cand_x_q, cand_x_d;
  logic [7:0][7:0] cand_y_q, cand_y_d;
  logic [7:0][7:0] commit_x_q, commit_x_d;
  logic [7:0][7:0] commit_y_q, commit_y_d;
  logic [7:0][5:0] code_q, code_d;
  logic [7:0]      pending_q, pending_d;
  logic            dirty_q, dirty_d;
  logic            restore_hit_q, restore_hit_d;
  logic [2:0]      idx_q, idx_d;
  logic [5:0]      num_q, num_d;

  logic [15:0] pos_off;
  logic [15:0] code_off;
  logic        pos_hit;
  logic        code_hit;
  logic [2:0]  pos_idx;
  logic [2:0]  code_idx;
  logic        issue_go;
  logic [2:0]  next_idx;

  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    lowest_set = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) lowest_set = 3'(i);
    end
  endfunction

  // Each window spans 16 bytes: bits [3:1] select the sprite, bit 0 selects X/Y.
  assign pos_off  = cpu_addr - POS_BASE;
  assign code_off = cpu_addr - CODE_BASE;
  assign pos_hit  = cpu_wr_en && (pos_off < 16'd16);
  assign code_hit = cpu_wr_en && (code_off < 16'd16) && !code_off[0];
  assign pos_idx  = pos_off[3:1];
  assign code_idx = code_off[3:1];

  assign next_idx = lowest_set(pending_q);
  assign issue_go = (state_q == IDLE) && (pending_q != 8'd0) && !checker_busy;

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (issue_go) state_d = ISSUE;
      ISSUE:     state_d = checker_busy ? WAIT_DONE : RESOLVE;
      WAIT_DONE: if (!checker_busy) state_d = RESOLVE;
      RESOLVE:   state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    sprite_update = (state_q == ISSUE);
  end

  assign update_index = idx_q;
  assign sprite_num   = num_q;
  assign sprite_x     = commit_x_q;
  assign sprite_y     = commit_y_q;
  assign pending      = pending_q;

  // Datapath next-state: FSM actions first, CPU snoop last so a same-cycle write wins.
  always_comb begin
    // NOTE: every _d starts from its held value so no branch can leave it unassigned and infer a latch.
    cand_x_d      = cand_x_q;
    cand_y_d      = cand_y_q;
    commit_x_d    = commit_x_q;
    commit_y_d    = commit_y_q;
    code_d        = code_q;
    pending_d     = pending_q;
    dirty_d       = dirty_q;
    restore_hit_d = restore_hit_q;
    idx_d         = idx_q;
    num_d         = num_q;

    case (state_q)
      IDLE: begin
        if (issue_go) begin
          idx_d         = next_idx;
          num_d         = code_q[next_idx];
          dirty_d       = 1'b0;
          restore_hit_d = 1'b0;
        end
      end
      WAIT_DONE: begin
        if (restore[idx_q]) restore_hit_d = 1'b1;
      end
      RESOLVE: begin
        if (restore_hit_q) begin
          cand_x_d[idx_q] = commit_x_q[idx_q];
          cand_y_d[idx_q] = commit_y_q[idx_q];
        end else begin
          commit_x_d[idx_q] = cand_x_q[idx_q];
          commit_y_d[idx_q] = cand_y_q[idx_q];
        end
        pending_d[idx_q] = dirty_q;
      end
      default: ;
    endcase

    if (pos_hit) begin
      if (pos_off[0]) cand_y_d[pos_idx] = cpu_wr_data;
      else            cand_x_d[pos_idx] = cpu_wr_data;
      pending_d[pos_idx] = 1'b1;
      if ((state_q != IDLE) && (pos_idx == idx_q)) dirty_d = 1'b1;
    end

    if (code_hit) begin
      code_d[code_idx] = cpu_wr_data[7:2];
      if ((state_q != IDLE) && (code_idx == idx_q)) dirty_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the per-sprite arrays are ordinary flops rather than a RAM, so they clear with everything else.
      cand_x_q      <= '0;
      cand_y_q      <= '0;
      commit_x_q    <= '0;
      commit_y_q    <= '0;
      code_q        <= '0;
      pending_q     <= '0;
      dirty_q       <= 1'b0;
      restore_hit_q <= 1'b0;
      idx_q         <= '0;
      num_q         <= '0;
    end else begin
      cand_x_q      <= cand_x_d;
      cand_y_q      <= cand_y_d;
      commit_x_q    <= commit_x_d;
      commit_y_q    <= commit_y_d;
      code_q        <= code_d;
      pending_q     <= pending_d;
      dirty_q       <= dirty_d;
      restore_hit_q <= restore_hit_d;
      idx_q         <= idx_d;
      num_q         <= num_d;
    end
  end

endmodule

// File: tb/tb_sprite_move_requester.sv
// Directed bench: expected checker requests go into a queue that a negedge monitor
// drains whenever sprite_update is seen; positions and pending are checked directly.
module tb_sprite_move_requester;

  logic            clk = 1'b0;
  logic            rst;
  logic            cpu_wr_en;
  logic [15:0]     cpu_addr;
  logic [7:0]      cpu_wr_data;
  logic            checker_busy;
  logic [7:0]      restore;
  logic            sprite_update;
  logic [2:0]      update_index;
  logic [5:0]      sprite_num;
  logic [7:0][7:0] sprite_x;
  logic [7:0][7:0] sprite_y;
  logic [7:0]      pending;

  int total = 0;
  int bad   = 0;
  logic [8:0] exp_q[$];
  logic [8:0] mon_exp;

  always #5 clk = ~clk;

  sprite_move_requester dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_wr_en    (cpu_wr_en),
    .cpu_addr     (cpu_addr),
    .cpu_wr_data  (cpu_wr_data),
    .checker_busy (checker_busy),
    .restore      (restore),
    .sprite_update(sprite_update),
    .update_index (update_index),
    .sprite_num   (sprite_num),
    .sprite_x     (sprite_x),
    .sprite_y     (sprite_y),
    .pending      (pending)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void expect_req(input logic [2:0] idx, input logic [5:0] num);
    exp_q.push_back({idx, num});
  endfunction

  // Scoreboard monitor: every request pulse must match the next expected {index, code}.
  always @(negedge clk) begin
    if (rst && sprite_update) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_req: got idx=%0d num=%0d expected none", update_index, sprite_num);
      end else begin
        mon_exp = exp_q.pop_front();
        check("req_idx_num", {55'd0, update_index, sprite_num}, {55'd0, mon_exp});
      end
    end
  end

  // All stimulus tasks start and end on a falling edge.
  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    cpu_wr_en   = 1'b1;
    cpu_addr    = a;
    cpu_wr_data = d;
    @(negedge clk);
    cpu_wr_en   = 1'b0;
  endtask

  // Wait for a request pulse, answer it with the given busy level, step one cycle.
  task automatic wait_issue(input logic busy_after);
    bit found = 0;
    for (int i = 0; i < 30; i++) begin
      if (sprite_update) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    if (!found) begin
      total++;
      bad++;
      $display("FAIL issue_timeout: got no sprite_update expected one within 30 cycles");
    end
    checker_busy = busy_after;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; cpu_wr_en = 1'b0; cpu_addr = '0; cpu_wr_data = '0;
    checker_busy = 1'b0; restore = '0;
    repeat (2) @(negedge clk);
    check("rst_update", {63'd0, sprite_update}, 64'd0);
    check("rst_index",  {61'd0, update_index}, 64'd0);
    check("rst_num",    {58'd0, sprite_num}, 64'd0);
    check("rst_pending",{56'd0, pending}, 64'd0);
    check("rst_x", sprite_x, 64'd0);
    check("rst_y", sprite_y, 64'd0);
    rst = 1'b1;

    // Sprite 0, unchecked move, code 0xB0 -> 44
    expect_req(3'd0, 6'd44);
    cpu_write(16'h4FF0, 8'hB0);
    cpu_write(16'h5060, 8'h40);
    cpu_write(16'h5061, 8'h50);
    wait_issue(1'b0);
    check("s0_x_not_yet", {56'd0, sprite_x[0]}, 64'd0);
    @(negedge clk);
    check("s0_x", {56'd0, sprite_x[0]}, 64'h40);
    check("s0_y", {56'd0, sprite_y[0]}, 64'h50);
    check("s0_pending", {56'd0, pending}, 64'd0);

    // Sprite 2 committed at (0x10,0x20)
    expect_req(3'd2, 6'd0);
    cpu_write(16'h5064, 8'h10);
    cpu_write(16'h5065, 8'h20);
    wait_issue(1'b0);
    @(negedge clk);
    check("s2_init_x", {56'd0, sprite_x[2]}, 64'h10);
    check("s2_init_y", {56'd0, sprite_y[2]}, 64'h20);

    // Sprite 2 X=0x18 with restore -> reverted
    expect_req(3'd2, 6'd0);
    cpu_write(16'h5064, 8'h18);
    wait_issue(1'b1);
    restore = 8'h24;
    @(negedge clk);
    restore = 8'h00;
    repeat (2) @(negedge clk);
    check("s2_wait_x", {56'd0, sprite_x[2]}, 64'h10);
    check("s2_wait_pending", {56'd0, pending}, 64'h04);
    checker_busy = 1'b0;
    repeat (2) @(negedge clk);
    check("s2_restore_x", {56'd0, sprite_x[2]}, 64'h10);
    check("s2_restore_pending", {56'd0, pending}, 64'd0);

    // Only Y moves now; committed X proves the candidate X was reverted
    expect_req(3'd2, 6'd0);
    cpu_write(16'h5065, 8'h21);
    wait_issue(1'b0);
    @(negedge clk);
    check("s2_cand_reverted_x", {56'd0, sprite_x[2]}, 64'h10);
    check("s2_new_y", {56'd0, sprite_y[2]}, 64'h21);

    // Sprite 2 X=0x18, restore bits only on other sprites -> commits
    expect_req(3'd2, 6'd0);
    cpu_write(16'h5064, 8'h18);
    wait_issue(1'b1);
    restore = 8'hFB;
    repeat (3) @(negedge clk);
    restore = 8'h00;
    checker_busy = 1'b0;
    repeat (2) @(negedge clk);
    check("s2_commit_x", {56'd0, sprite_x[2]}, 64'h18);
    check("s2_commit_pending", {56'd0, pending}, 64'd0);

    // Sprites 5 and 1 pending together (busy held) -> lowest index first
    checker_busy = 1'b1;
    cpu_write(16'h4FF2, 8'h0C);
    cpu_write(16'h4FFA, 8'hFC);
    cpu_write(16'h506A, 8'h55);
    cpu_write(16'h5062, 8'h11);
    @(negedge clk);
    check("busy_hold_pending", {56'd0, pending}, 64'h22);
    expect_req(3'd1, 6'd3);
    expect_req(3'd5, 6'd63);
    checker_busy = 1'b0;
    wait_issue(1'b0);
    wait_issue(1'b0);
    @(negedge clk);
    check("s1_x", {56'd0, sprite_x[1]}, 64'h11);
    check("s5_x", {56'd0, sprite_x[5]}, 64'h55);
    check("s15_pending", {56'd0, pending}, 64'd0);

    // Sprite 3: write during WAIT_DONE, then restore -> re-checked
    expect_req(3'd3, 6'd0);
    cpu_write(16'h5066, 8'h33);
    wait_issue(1'b0);
    @(negedge clk);
    check("s3_init_x", {56'd0, sprite_x[3]}, 64'h33);
    expect_req(3'd3, 6'd0);
    expect_req(3'd3, 6'd0);
    cpu_write(16'h5066, 8'h44);
    wait_issue(1'b1);
    cpu_write(16'h5066, 8'h66);
    restore = 8'h08;
    @(negedge clk);
    restore = 8'h00;
    checker_busy = 1'b0;
    repeat (2) @(negedge clk);
    check("s3_dirty_pending", {56'd0, pending}, 64'h08);
    check("s3_dirty_x", {56'd0, sprite_x[3]}, 64'h33);
    wait_issue(1'b0);
    @(negedge clk);
    check("s3_final_x", {56'd0, sprite_x[3]}, 64'h33);
    check("s3_final_pending", {56'd0, pending}, 64'd0);

    // Sprite 4: write in RESOLVE beats the revert
    expect_req(3'd4, 6'd0);
    cpu_write(16'h5068, 8'h70);
    wait_issue(1'b0);
    @(negedge clk);
    expect_req(3'd4, 6'd0);
    expect_req(3'd4, 6'd0);
    cpu_write(16'h5068, 8'h71);
    wait_issue(1'b1);
    restore = 8'h10;
    @(negedge clk);
    restore = 8'h00;
    checker_busy = 1'b0;
    @(negedge clk);
    cpu_write(16'h5068, 8'h99);
    check("s4_resolve_pending", {56'd0, pending}, 64'h10);
    check("s4_resolve_x", {56'd0, sprite_x[4]}, 64'h70);
    wait_issue(1'b0);
    @(negedge clk);
    check("s4_final_x", {56'd0, sprite_x[4]}, 64'h99);

    // Reset during WAIT_DONE, busy stays high afterwards
    expect_req(3'd0, 6'd44);
    cpu_write(16'h5060, 8'h77);
    wait_issue(1'b1);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_update", {63'd0, sprite_update}, 64'd0);
    check("mid_rst_index", {61'd0, update_index}, 64'd0);
    check("mid_rst_num", {58'd0, sprite_num}, 64'd0);
    check("mid_rst_pending", {56'd0, pending}, 64'd0);
    check("mid_rst_x", sprite_x, 64'd0);
    check("mid_rst_y", sprite_y, 64'd0);
    rst = 1'b1;
    cpu_write(16'h5300, 8'h12);
    repeat (3) @(negedge clk);
    check("outside_pending", {56'd0, pending}, 64'd0);
    cpu_write(16'h5062, 8'h05);
    @(negedge clk);
    check("post_rst_busy_pending", {56'd0, pending}, 64'h02);
    repeat (4) @(negedge clk);
    expect_req(3'd1, 6'd0);
    checker_busy = 1'b0;
    wait_issue(1'b0);
    @(negedge clk);
    check("post_rst_s1_x", {56'd0, sprite_x[1]}, 64'h05);
    check("post_rst_pending", {56'd0, pending}, 64'd0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sprite_move_requester.md
Name: sprite_move_requester

Overview:
- Snoops CPU bus writes to the sprite code and position registers.
- Keeps a candidate position and a committed (last-accepted) position for each of the 8 hardware sprites.
- Is the initiator for the collision checker: raises sprite_update with update_index, sprite_num and committed positions, then watches the checker's pause/restore response.
- On restore, reverts the candidate to the committed position; otherwise commits the candidate.
- Sits between the CPU bus and the collision checker, in the video/sprite path.

Parameters:
POS_BASE, 16'h5060, address of sprite 0 X register; sprite i uses X at POS_BASE+2i and Y at POS_BASE+2i+1.
CODE_BASE, 16'h4FF0, address of sprite 0 attribute byte; sprite i code byte at CODE_BASE+2i.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-low reset
cpu_wr_en  input  1  CPU write strobe, one cycle per write
cpu_addr  input  16  CPU write address
cpu_wr_data  input  8  CPU write data
checker_busy  input  1  collision checker pause output (cpu_pause)
restore  input  8  per-sprite restore flags from checker
sprite_update  output  1  one-cycle request to checker
update_index  output  3  sprite being checked
sprite_num  output  6  code of sprite update_index (attribute bits 7:2)
sprite_x  output  [7:0][7:0]  committed X per sprite
sprite_y  output  [7:0][7:0]  committed Y per sprite
pending  output  8  sprites with an unresolved move

Behaviour:
- Reset (rst==0 at a clk edge) clears all of the following to 0:
  - cand_x/cand_y, commit_x/commit_y, code registers;
  - pending, dirty, restore_hit;
  - sprite_update, update_index, sprite_num.
  - FSM goes to IDLE.
- Snoop, every cycle with cpu_wr_en=1:
  - addr==POS_BASE+2i: cand_x[i]<=data, pending[i]<=1.
  - addr==POS_BASE+2i+1: cand_y[i]<=data, pending[i]<=1.
  - addr==CODE_BASE+2i: code[i]<=data[7:2]; pending is not touched.
  - Any other address is ignored.
  - If i equals the in-flight index while the FSM is not IDLE, dirty<=1.
- sprite_x/sprite_y are driven from commit_x/commit_y, so the checker's wall write-back restores the committed value.
- sprite_num = code[update_index]; registered, and valid in the ISSUE cycle.
- FSM:
  - IDLE:
    - If pending!=0 and checker_busy==0: update_index<=lowest set bit of pending, dirty<=0, restore_hit<=0, go to ISSUE.
    - Otherwise stay in IDLE.
  - ISSUE:
    - sprite_update=1 for exactly this cycle.
    - The checker asserts busy combinationally in the same cycle for pacman/ghost codes.
    - checker_busy==1 -> WAIT_DONE; checker_busy==0 -> RESOLVE (sprite not subject to collision).
  - WAIT_DONE:
    - sprite_update=0.
    - restore[update_index]==1 in any cycle sets restore_hit<=1.
    - checker_busy==0 -> RESOLVE.
  - RESOLVE (one cycle):
    - restore_hit=1: cand_x/y[idx]<=commit_x/y[idx].
    - restore_hit=0: commit_x/y[idx]<=cand_x/y[idx].
    - pending[idx]<=dirty. A write that arrived after ISSUE keeps the sprite pending and it is re-checked.
    - Go to IDLE.
- Latency:
  - Write to sprite_update: 2 cycles (write, IDLE decision, ISSUE).
  - Unchecked sprite: commit 2 cycles after ISSUE.
- Simultaneous events:
  - A CPU write to cand[idx] in the RESOLVE cycle beats the revert: cand takes the CPU data and pending[idx] stays 1 via dirty.
  - A CPU write in the RESOLVE cycle to a different sprite is independent.
- restore bits for indices other than update_index are ignored.
- A rst low mid-transaction aborts. A checker_busy that stays high after reset is tolerated: IDLE waits for it to fall before issuing.
- Round-robin is not required. The lowest-index-first policy is fixed.

Test Plan:
- Reset, then write 0x5060=0x40, 0x5061=0x50, code 0x4FF0=0xB0 (code 44), no busy -> sprite_update pulse with update_index=0, sprite_num=44. sprite_x[0] becomes 0x40 and sprite_y[0] 0x50 two cycles after ISSUE; pending=0.
- Sprite 2 committed at (0x10,0x20). Write X=0x18. Checker holds busy for 4 cycles and pulses restore[2] -> sprite_x[2] stays 0x10 and cand_x reverts to 0x10; pending[2]=0.
- Same as the previous case but with no restore -> sprite_x[2]=0x18 after busy falls.
- Writes to sprites 5 and 1 in the same window -> sprite 1 issued first, then sprite 5. Each gets its own sprite_update pulse separated by resolution.
- Write to sprite 3 during its WAIT_DONE, then restore asserted -> sprite_x[3] unchanged, pending[3] stays 1, and a second sprite_update for index 3 follows.
- Drive rst low during WAIT_DONE -> next cycle: all outputs 0, FSM IDLE, pending=0. A write to 0x5300 (outside the window) produces no request.
